// File: rtl/fan_timer_ctrl.sv
// fan_timer_ctrl: fan shutdown timer with a 1 s prescaler and a countdown to fan-off.
// Define TIMER_PAUSE_EN to let i_btn_pause toggle between RUN and PAUSE.
module fan_timer_ctrl #(
  parameter int TICK_DIV = 100_000_000,
  parameter int T1_SEC   = 60,
  parameter int T2_SEC   = 180,
  parameter int T3_SEC   = 300,
  parameter int SEC_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_fan_req,
  input  logic             i_btn_timer,
  input  logic             i_btn_clear,
  input  logic             i_btn_pause,
  output logic             o_fan_en,
  output logic [1:0]       o_state,
  output logic [1:0]       o_preset,
  output logic [SEC_W-1:0] o_remaining,
  output logic             o_expired
);
  localparam int PW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] preset_q, preset_d, next_preset;
  logic [SEC_W-1:0] rem_q, rem_d, reload;
  logic [PW-1:0] presc_q, presc_d;
  logic fan_q, fan_d, exp_q, exp_d, tick, stop, pause_btn;
`ifdef TIMER_PAUSE_EN
  assign pause_btn = i_btn_pause;
`else
  assign pause_btn = i_btn_pause & 1'b0;
`endif
  assign next_preset = preset_q + 2'd1;
  assign reload = next_preset == 2'd1 ? SEC_W'(T1_SEC) :
                  next_preset == 2'd2 ? SEC_W'(T2_SEC) :
                  next_preset == 2'd3 ? SEC_W'(T3_SEC) : '0;
  assign tick = presc_q == PW'(TICK_DIV - 1);
  assign stop = i_btn_clear | ~i_fan_req;
  always_comb begin
    state_d  = state_q;
    preset_d = preset_q;
    rem_d    = rem_q;
    presc_d  = presc_q;
    exp_d    = 1'b0;
    case (state_q)
      IDLE: if (!stop && i_btn_timer) begin
        state_d  = RUN;
        preset_d = 2'd1;
        rem_d    = SEC_W'(T1_SEC);
        presc_d  = '0;
      end
      RUN, PAUSE: if (stop) begin
        state_d  = IDLE;
        preset_d = 2'd0;
        rem_d    = '0;
        presc_d  = '0;
      end else if (i_btn_timer) begin
        // a reload discards any tick landing on the same cycle
        state_d  = next_preset == 2'd0 ? IDLE : RUN;
        preset_d = next_preset;
        rem_d    = reload;
        presc_d  = '0;
      end else if (pause_btn) begin
        state_d = state_q == RUN ? PAUSE : RUN;
      end else if (state_q == RUN) begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == SEC_W'(1)) begin
            state_d  = DONE;
            preset_d = 2'd0;
            exp_d    = 1'b1;
          end
        end
      end
      DONE: if (stop) state_d = IDLE;
    endcase
    fan_d = state_d == IDLE ? i_fan_req : state_d == RUN;
  end
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= IDLE;
      preset_q <= 2'd0;
      rem_q    <= '0;
      presc_q  <= '0;
      fan_q    <= 1'b0;
      exp_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      preset_q <= preset_d;
      rem_q    <= rem_d;
      presc_q  <= presc_d;
      fan_q    <= fan_d;
      exp_q    <= exp_d;
    end
  end
  assign o_fan_en    = fan_q;
  assign o_state     = state_q;
  assign o_preset    = preset_q;
  assign o_remaining = rem_q;
  assign o_expired   = exp_q;
endmodule

// File: tb/tb_fan_timer_ctrl.sv
// tb_fan_timer_ctrl: directed and random stimulus checked against an elapsed-time model.
module tb_fan_timer_ctrl;
  localparam int TD = 4, T1 = 3, T2 = 5, T3 = 7, SW = 8;
`ifdef TIMER_PAUSE_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif
  logic i_clk = 1'b0, i_reset = 1'b0;
  logic i_fan_req = 1'b1, i_btn_timer = 1'b0, i_btn_clear = 1'b0, i_btn_pause = 1'b0;
  logic o_fan_en, o_expired;
  logic [1:0] o_state, o_preset;
  logic [SW-1:0] o_remaining;
  int n_checks = 0, n_fail = 0;
  int m_state = 0, m_preset = 0, m_elapsed = 0, m_fan = 0, m_exp = 0;
  int exp_p[4] = '{1, 2, 3, 0};
  int exp_r[4] = '{3, 5, 7, 0};

  fan_timer_ctrl #(.TICK_DIV(TD), .T1_SEC(T1), .T2_SEC(T2), .T3_SEC(T3), .SEC_W(SW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_fan_req(i_fan_req), .i_btn_timer(i_btn_timer),
    .i_btn_clear(i_btn_clear), .i_btn_pause(i_btn_pause), .o_fan_en(o_fan_en),
    .o_state(o_state), .o_preset(o_preset), .o_remaining(o_remaining), .o_expired(o_expired));

  always #5 i_clk = ~i_clk;

  function automatic int secs(int p);
    return p == 1 ? T1 : p == 2 ? T2 : p == 3 ? T3 : 0;
  endfunction

  // remaining seconds follow from how many RUN cycles have elapsed since the last load
  function automatic int m_rem();
    return (m_state == 1 || m_state == 2) ? secs(m_preset) - m_elapsed / TD : 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_preset = 0; m_elapsed = 0; m_fan = 0; m_exp = 0;
  endtask

  task automatic model_step();
    bit stop;
    m_exp = 0;
    if (!i_reset) begin
      model_reset();
      return;
    end
    stop = i_btn_clear || !i_fan_req;
    case (m_state)
      0: if (!stop && i_btn_timer) begin m_state = 1; m_preset = 1; m_elapsed = 0; end
      1, 2: begin
        if (stop) begin
          m_state = 0; m_preset = 0;
        end else if (i_btn_timer) begin
          m_preset = (m_preset + 1) % 4;
          m_elapsed = 0;
          m_state = m_preset == 0 ? 0 : 1;
        end else if (PE && i_btn_pause) begin
          m_state = 3 - m_state;
        end else if (m_state == 1) begin
          m_elapsed++;
          if (m_elapsed == secs(m_preset) * TD) begin
            m_state = 3; m_preset = 0; m_exp = 1;
          end
        end
      end
      default: if (stop) m_state = 0;
    endcase
    m_fan = m_state == 0 ? int'(i_fan_req) : int'(m_state == 1);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("state", 32'(o_state), m_state);
    chk("preset", 32'(o_preset), m_preset);
    chk("remaining", 32'(o_remaining), m_rem());
    chk("fan_en", 32'(o_fan_en), m_fan);
    chk("expired", 32'(o_expired), m_exp);
  endtask

  task automatic step(input logic f, input logic t, input logic c, input logic p);
    i_fan_req = f; i_btn_timer = t; i_btn_clear = c; i_btn_pause = p;
    @(posedge i_clk);
    model_step();
    #1 check_all();
  endtask

  task automatic async_reset();
    #3 i_reset = 1'b0;
    #1 model_reset();
    check_all();
    #1 i_reset = 1'b1;
  endtask

  initial begin
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("reset_fan", 32'(o_fan_en), 0);
    i_reset = 1'b1;
    step(1, 0, 0, 0);
    chk("release_fan", 32'(o_fan_en), 1);
    step(1, 1, 0, 0);
    chk("run_rem", 32'(o_remaining), 3);
    repeat (11) step(1, 0, 0, 0);
    chk("pre_expire", 32'(o_expired), 0);
    step(1, 0, 0, 0);
    chk("expire_pulse", 32'(o_expired), 1);
    chk("done_state", 32'(o_state), 3);
    step(1, 0, 0, 0);
    chk("expire_once", 32'(o_expired), 0);
    step(1, 0, 1, 0);
    chk("clear_fan", 32'(o_fan_en), 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 0);
      chk("cycle_preset", 32'(o_preset), exp_p[i]);
      chk("cycle_rem", 32'(o_remaining), exp_r[i]);
      step(1, 0, 0, 0);
    end
    chk("cycle_idle", 32'(o_state), 0);
    step(1, 1, 0, 0);
    repeat (4) step(1, 0, 0, 0);
    chk("mid_rem", 32'(o_remaining), 2);
    step(0, 1, 0, 0);
    chk("drop_state", 32'(o_state), 0);
    chk("drop_exp", 32'(o_expired), 0);
`ifdef TIMER_PAUSE_EN
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    repeat (20) step(1, 0, 0, 0);
    chk("pause_rem", 32'(o_remaining), 5);
    chk("pause_fan", 32'(o_fan_en), 0);
    step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("resume_rem", 32'(o_remaining), 4);
    step(1, 0, 1, 0);
`endif
    step(1, 1, 0, 0);
    repeat (6) step(1, 0, 0, 0);
    async_reset();
    chk("areset_state", 32'(o_state), 0);
    repeat (12) step(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 19) != 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 79) == 0, $urandom_range(0, 24) == 0);
      if ($urandom_range(0, 399) == 0) async_reset();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
